// File: rtl/parse_sequencer_pkg.sv
// Shared definitions for the parse sequencer: FSM encoding, RESULT codes,
// parser STAT bit positions and lexer token field slices.
package parse_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRST = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] RES_NONE   = 2'd0;
  localparam logic [1:0] RES_ACCEPT = 2'd1;
  localparam logic [1:0] RES_ERROR  = 2'd2;
  localparam logic [1:0] RES_FAULT  = 2'd3;  // timeout or rule overflow

  // STAT = {running, accept, error}
  localparam int STAT_RUN = 2;
  localparam int STAT_ACC = 1;
  localparam int STAT_ERR = 0;

  // token = {kind, attr}
  localparam int TOK_KIND_HI = 15;
  localparam int TOK_KIND_LO = 8;
  localparam int TOK_ATTR_HI = 7;
  localparam int TOK_ATTR_LO = 0;

  function automatic logic [7:0] tok_kind(input logic [15:0] tok);
    return tok[TOK_KIND_HI:TOK_KIND_LO];
  endfunction

endpackage

// File: rtl/sync_fifo_16.sv
// 16-bit synchronous FIFO with first-word-fall-through head.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   flush               empties the FIFO this edge (wins over push/pop)
//   push, wdata         write; accepted when not full, or when full and popping
//   pop                 read; ignored when empty
//   rdata               head word, forced to 0 while empty
//   full, empty         status from current pointers
//   empty_nxt           emptiness after this edge, for registered consumers
module sync_fifo_16 #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        push,
  input  logic [15:0] wdata,
  input  logic        pop,
  output logic [15:0] rdata,
  output logic        full,
  output logic        empty,
  output logic        empty_nxt
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates full from empty when the indices match.
  logic [AW:0]  wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [15:0]  mem [DEPTH];
  logic         do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign wr_nxt    = flush ? '0 : wr_ptr + {{AW{1'b0}}, do_push};
  assign rd_nxt    = flush ? '0 : rd_ptr + {{AW{1'b0}}, do_pop};
  assign empty_nxt = (wr_nxt == rd_nxt);

  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/parse_sequencer.sv
// Runs one LR parse job: holds the parser in reset, streams buffered lexer
// tokens to it, captures emitted reduce rules and reports the outcome.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start, abort               job control pulses (abort wins)
//   busy, done, result         job status; result uses RES_* codes
//   rule_cnt                   rules captured this job, saturating
//   t_valid/t_ready/t_data     lexer token input
//   r_valid/r_ready/r_data     rule output stream
//   p_rst                      parser reset (active high)
//   p_valid/p_token/p_receive  parser token handshake
//   p_stat                     parser {running, accept, error}
//   p_ovalid/p_orule           parser reduce-rule output
module parse_sequencer
  import parse_sequencer_pkg::*;
#(
  parameter int TOK_DEPTH  = 16,
  parameter int RULE_DEPTH = 64,
  parameter int PRST_CYC   = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [1:0]  result,
  output logic [15:0] rule_cnt,
  input  logic        t_valid,
  output logic        t_ready,
  input  logic [15:0] t_data,
  output logic        r_valid,
  input  logic        r_ready,
  output logic [15:0] r_data,
  output logic        p_rst,
  output logic        p_valid,
  output logic [15:0] p_token,
  input  logic        p_receive,
  input  logic [2:0]  p_stat,
  input  logic        p_ovalid,
  input  logic [15:0] p_orule
);

  localparam int PW = (PRST_CYC > 1) ? $clog2(PRST_CYC) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t        state, state_nxt;
  logic [PW-1:0] prst_cnt;
  logic [TW-1:0] wd_cnt;
  logic          stat_en;

  logic          tok_push, tok_pop, tok_full, tok_empty, tok_empty_nxt;
  logic          rule_push, rule_pop, rule_full, rule_empty, rule_empty_nxt;
  logic          flush, job_start;
  logic          rule_ovf, wd_expire, stat_hit, fault;

  logic          busy_d, done_d, p_rst_d, p_valid_d;
  logic [1:0]    result_d;
  logic [15:0]   rule_cnt_d;

  // Running bit and the rule FIFO look-ahead are not needed here.
  logic unused_ok;
  assign unused_ok = &{1'b0, p_stat[STAT_RUN], rule_empty_nxt};

  // ---------------- datapath glue ----------------
  assign job_start = (state_nxt == S_PRST) && (state != S_PRST);
  assign flush     = abort | job_start;

  assign t_ready  = (state == S_RUN) && !tok_full;
  assign tok_push = t_valid & t_ready;
  assign tok_pop  = p_receive & p_valid;  // p_valid implies RUN and non-empty

  assign r_valid   = !rule_empty;
  assign rule_pop  = r_ready & r_valid;
  assign rule_push = (state == S_RUN) && p_ovalid && (!rule_full || rule_pop);
  assign rule_ovf  = (state == S_RUN) && p_ovalid && rule_full && !rule_pop;

  // Counts every presented-but-unreceived cycle, including parser reduce runs.
  assign wd_expire = (TIMEOUT != 0) && p_valid && !p_receive &&
                     (wd_cnt == TW'(TIMEOUT - 1));

  // STAT is ignored on the first RUN cycle while the parser leaves reset.
  assign stat_hit = stat_en && (p_stat[STAT_ACC] || p_stat[STAT_ERR]);
  assign fault    = rule_ovf || wd_expire;

  sync_fifo_16 #(.DEPTH(TOK_DEPTH)) u_tok_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (tok_push),
    .wdata     (t_data),
    .pop       (tok_pop),
    .rdata     (p_token),
    .full      (tok_full),
    .empty     (tok_empty),
    .empty_nxt (tok_empty_nxt)
  );

  sync_fifo_16 #(.DEPTH(RULE_DEPTH)) u_rule_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (rule_push),
    .wdata     (p_orule),
    .pop       (rule_pop),
    .rdata     (r_data),
    .full      (rule_full),
    .empty     (rule_empty),
    .empty_nxt (rule_empty_nxt)
  );

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      prst_cnt <= '0;
      stat_en  <= 1'b0;
      wd_cnt   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= RES_NONE;
      rule_cnt <= '0;
      p_rst    <= 1'b1;
      p_valid  <= 1'b0;
    end else begin
      state    <= state_nxt;
      prst_cnt <= (state == S_PRST) ? prst_cnt + 1'b1 : '0;
      stat_en  <= (state == S_RUN);
      wd_cnt   <= (!p_valid || p_receive) ? '0 : wd_cnt + 1'b1;
      busy     <= busy_d;
      done     <= done_d;
      result   <= result_d;
      rule_cnt <= rule_cnt_d;
      p_rst    <= p_rst_d;
      p_valid  <= p_valid_d;
    end
  end

  // ---------------- next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_PRST;
      S_PRST:         if (prst_cnt == PW'(PRST_CYC - 1)) state_nxt = S_RUN;
      S_RUN:          if (fault || stat_hit) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  // ---------------- outputs (next values, registered above) ----------------
  always_comb begin
    busy_d    = (state_nxt == S_PRST) || (state_nxt == S_RUN);
    done_d    = (state_nxt == S_DONE);
    p_rst_d   = (state_nxt == S_IDLE) || (state_nxt == S_PRST);
    p_valid_d = (state_nxt == S_RUN) && !tok_empty_nxt;

    result_d = result;
    if (flush)
      result_d = RES_NONE;
    else if ((state == S_RUN) && (state_nxt == S_DONE))
      result_d = fault              ? RES_FAULT :
                 p_stat[STAT_ERR]   ? RES_ERROR : RES_ACCEPT;

    rule_cnt_d = rule_cnt;
    if (flush)
      rule_cnt_d = '0;
    else if (rule_push && (rule_cnt != 16'hFFFF))
      rule_cnt_d = rule_cnt + 16'd1;
  end

endmodule
